// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand-forwarding and hazard scoreboard for an in-order pipeline.
// Tracks the destination register and remaining latency of each producer that has
// left D. It selects a bypass source per D-stage read port and raises stall when
// a needed operand is not yet forwardable.
// Optional feature: define FWD_MD_EN to add the multiply/divide busy counter and
// its HI/LO stall. Without it, md_busy is 0 and the md_* inputs are ignored.
module fwd_scoreboard #(
  parameter int DEPTH   = 3,
  parameter int NREAD   = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  localparam int SELW   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  issue_valid,
  input  logic                  issue_wen,
  input  logic [4:0]            issue_waddr,
  input  logic [2:0]            issue_lat,
  input  logic [5*NREAD-1:0]    rd_addr,
  input  logic [NREAD-1:0]      rd_use,
  input  logic                  flush,
  input  logic                  md_start,
  input  logic                  md_is_div,
  input  logic                  md_use,
  output logic [SELW*NREAD-1:0] fwd_sel,
  output logic                  stall,
  output logic                  md_busy
);

  typedef struct packed {
    logic       valid;
    logic [4:0] waddr;
    logic [2:0] lat;
  } slot_t;

  // Slot k holds the producer that entered E k-1 cycles ago (slot 1 = E).
  slot_t slots [1:DEPTH];

  logic gpr_stall;
  logic md_stall;
  logic slot1_load;

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  // A D instruction is recorded only if it really advances into E and writes a GPR.
  assign slot1_load = issue_valid && issue_wen && (issue_waddr != 5'd0) && !stall && !flush;

  // Producer shift register: new entry into slot 1, older ones age and count down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the slots are a handful of flops, not a RAM, so clearing every entry
      // in reset is what lets a mid-operation reset discard all in-flight producers.
      for (int i = 1; i <= DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every slot sample its neighbour's old
      // value, so the shift works regardless of loop order.
      slots[1] <= slot1_load ? '{valid: 1'b1, waddr: issue_waddr, lat: issue_lat} : '0;
      for (int i = 2; i <= DEPTH; i++) begin
        slots[i].valid <= slots[i-1].valid;
        slots[i].waddr <= slots[i-1].waddr;
        slots[i].lat   <= sat_dec(slots[i-1].lat);
      end
    end
  end

  // Per read port: youngest matching producer decides between bypass and stall.
  always_comb begin : match_logic
    logic            hit;
    logic            ready;
    logic [SELW-1:0] hit_slot;
    // NOTE: every output and temporary gets a default before the loops; a path that
    // leaves one unassigned would infer a latch.
    fwd_sel   = '0;
    gpr_stall = 1'b0;
    hit       = 1'b0;
    ready     = 1'b0;
    hit_slot  = '0;
    for (int p = 0; p < NREAD; p++) begin
      hit      = 1'b0;
      ready    = 1'b0;
      hit_slot = '0;
      // Scan oldest to youngest so the youngest match overwrites the rest.
      for (int k = DEPTH; k >= 1; k--) begin
        if (slots[k].valid && (slots[k].waddr == rd_addr[5*p +: 5])) begin
          hit      = 1'b1;
          ready    = (slots[k].lat == 3'd0);
          hit_slot = SELW'(k);
        end
      end
      // $0 is hardwired; never bypass or stall on it.
      if (rd_addr[5*p +: 5] == 5'd0) begin
        hit = 1'b0;
      end
      if (hit && ready) begin
        fwd_sel[SELW*p +: SELW] = hit_slot;
      end
      if (hit && !ready && rd_use[p]) begin
        gpr_stall = 1'b1;
      end
    end
  end

`ifdef FWD_MD_EN
  logic [3:0] md_count;

  // Multiply/divide busy counter: loads on an accepted start, then counts down to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_count <= 4'd0;
    end else if (md_start && issue_valid && !stall && !flush && (md_count == 4'd0)) begin
      md_count <= md_is_div ? 4'(DIV_LAT) : 4'(MUL_LAT);
    end else if (md_count != 4'd0) begin
      md_count <= md_count - 4'd1;
    end
  end

  assign md_busy  = (md_count != 4'd0);
  assign md_stall = md_use && md_busy;
`else
  logic unused_md;
  assign unused_md = ^{md_start, md_is_div, md_use, 4'(MUL_LAT), 4'(DIV_LAT)};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

  assign stall = gpr_stall || md_stall;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Testbench for fwd_scoreboard (DEPTH=3, NREAD=2). Directed scenarios check fixed
// expectations. A randomized phase compares every cycle against a time-based model.
// The model records which producer issued how many cycles ago, and with what
// latency.
module tb_fwd_scoreboard;

  localparam int DEPTH   = 3;
  localparam int NREAD   = 2;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int SELW    = $clog2(DEPTH + 1);
`ifdef FWD_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  issue_valid;
  logic                  issue_wen;
  logic [4:0]            issue_waddr;
  logic [2:0]            issue_lat;
  logic [5*NREAD-1:0]    rd_addr;
  logic [NREAD-1:0]      rd_use;
  logic                  flush;
  logic                  md_start;
  logic                  md_is_div;
  logic                  md_use;
  logic [SELW*NREAD-1:0] fwd_sel;
  logic                  stall;
  logic                  md_busy;

  int n_vec = 0;
  int n_err = 0;

  fwd_scoreboard #(
    .DEPTH(DEPTH), .NREAD(NREAD), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_waddr(issue_waddr), .issue_lat(issue_lat),
    .rd_addr(rd_addr), .rd_use(rd_use), .flush(flush),
    .md_start(md_start), .md_is_div(md_is_div), .md_use(md_use),
    .fwd_sel(fwd_sel), .stall(stall), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[k] = the instruction that entered E k cycles ago (k=0 is slot 1).
  typedef struct {
    bit       v;
    bit [4:0] a;
    int       lat;
  } ent_t;

  ent_t hist[$];
  int   cyc      = 0;
  int   busy_end = -1;  // last cycle during which the md unit is busy
  int   exp_sel [NREAD];
  bit   exp_stall;
  bit   exp_busy;

  task automatic model_clear();
    hist.delete();
    busy_end = -1;
  endtask

  task automatic model_eval();
    logic [4:0] a;
    bit         found;
    exp_busy  = MD_EN && (cyc <= busy_end);
    exp_stall = exp_busy && (md_use === 1'b1);
    for (int p = 0; p < NREAD; p++) begin
      exp_sel[p] = 0;
      a = rd_addr[5*p +: 5];
      found = 1'b0;
      if (a != 5'd0) begin
        for (int k = 0; k < hist.size(); k++) begin
          if (!found && hist[k].v && hist[k].a == a) begin
            found = 1'b1;
            // A result is forwardable once it has spent lat cycles beyond E.
            if (hist[k].lat <= k) exp_sel[p] = k + 1;
            else if (rd_use[p]) exp_stall = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_update();
    ent_t e;
    if (!reset_n) begin
      model_clear();
    end else begin
      e.v   = issue_valid && issue_wen && (issue_waddr != 5'd0) && !exp_stall && !flush;
      e.a   = issue_waddr;
      e.lat = int'(issue_lat);
      hist.push_front(e);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      if (MD_EN && md_start && issue_valid && !exp_stall && !flush && !exp_busy)
        busy_end = cyc + (md_is_div ? DIV_LAT : MUL_LAT);
    end
    cyc++;
  endtask

  function automatic logic [SELW*NREAD-1:0] exp_sel_vec();
    logic [SELW*NREAD-1:0] v;
    v = '0;
    for (int p = 0; p < NREAD; p++) v[SELW*p +: SELW] = SELW'(exp_sel[p]);
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    issue_valid = 1'b0; issue_wen = 1'b0; issue_waddr = '0; issue_lat = '0;
    rd_addr = '0; rd_use = '0; flush = 1'b0;
    md_start = 1'b0; md_is_div = 1'b0; md_use = 1'b0;
  endtask

  task automatic issue(input logic [4:0] r, input logic [2:0] l);
    issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = r; issue_lat = l;
  endtask

  // One clock: inputs were driven at the preceding negedge.
  task automatic tick();
    model_eval();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drain();
    idle_inputs();
    repeat (DEPTH + 1) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    issue(5'd3, 3'd2);
    rd_addr = {5'd3, 5'd3}; rd_use = '1; md_use = 1'b1; md_start = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({md_busy, stall, fwd_sel} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: busy=%0b stall=%0b sel=%h want all 0", md_busy, stall, fwd_sel);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
    model_clear();
    rd_addr = {5'd0, 5'd3}; rd_use = '1;
    #1;
    n_vec++;
    if ({md_busy, stall, fwd_sel} !== '0) begin
      n_err++;
      $display("FAIL reset_release: busy=%0b stall=%0b sel=%h want all 0", md_busy, stall, fwd_sel);
    end
    drain();
  endtask

  task automatic test_alu_forward();
    idle_inputs(); issue(5'd8, 3'd0); tick();
    idle_inputs(); rd_addr = {5'd0, 5'd8}; rd_use = 2'b01;
    #1; n_vec++;
    if ({stall, fwd_sel} !== {1'b0, 2'd0, 2'd1}) begin
      n_err++; $display("FAIL alu_fwd_e: stall=%0b sel=%h want stall=0 sel=1", stall, fwd_sel);
    end
    tick();
    #1; n_vec++;
    if ({stall, fwd_sel} !== {1'b0, 2'd0, 2'd2}) begin
      n_err++; $display("FAIL alu_fwd_m: stall=%0b sel=%h want stall=0 sel=2", stall, fwd_sel);
    end
    drain();
  endtask

  task automatic test_load_use();
    idle_inputs(); issue(5'd9, 3'd1); tick();
    idle_inputs(); rd_addr = {5'd0, 5'd9}; rd_use = 2'b01;
    #1; n_vec++;
    if ({stall, fwd_sel} !== {1'b1, 2'd0, 2'd0}) begin
      n_err++; $display("FAIL load_use_stall: stall=%0b sel=%h want stall=1 sel=0", stall, fwd_sel);
    end
    tick();
    #1; n_vec++;
    if ({stall, fwd_sel} !== {1'b0, 2'd0, 2'd2}) begin
      n_err++; $display("FAIL load_use_fwd: stall=%0b sel=%h want stall=0 sel=2", stall, fwd_sel);
    end
    drain();
  endtask

  task automatic test_youngest();
    idle_inputs(); issue(5'd5, 3'd0); tick();
    idle_inputs(); issue(5'd5, 3'd0); rd_addr = {5'd0, 5'd0}; rd_use = 2'b11;
    #1; n_vec++;
    if ({stall, fwd_sel} !== '0) begin
      n_err++; $display("FAIL read_r0: stall=%0b sel=%h want 0", stall, fwd_sel);
    end
    tick();
    idle_inputs(); rd_addr = {5'd0, 5'd5}; rd_use = 2'b11;
    #1; n_vec++;
    if ({stall, fwd_sel} !== {1'b0, 2'd0, 2'd1}) begin
      n_err++; $display("FAIL youngest_wins: stall=%0b sel=%h want stall=0 sel=1", stall, fwd_sel);
    end
    drain();
    // Younger producer not ready must stall even though an older copy is ready.
    idle_inputs(); issue(5'd5, 3'd0); tick();
    idle_inputs(); issue(5'd5, 3'd2); tick();
    idle_inputs(); rd_addr = {5'd5, 5'd0}; rd_use = 2'b10;
    #1; n_vec++;
    if ({stall, fwd_sel} !== {1'b1, 2'd0, 2'd0}) begin
      n_err++; $display("FAIL youngest_not_ready: stall=%0b sel=%h want stall=1 sel=0", stall, fwd_sel);
    end
    rd_use = 2'b00;
    #1; n_vec++;
    if ({stall, fwd_sel} !== '0) begin
      n_err++; $display("FAIL unused_operand: stall=%0b sel=%h want 0", stall, fwd_sel);
    end
    drain();
  endtask

  task automatic test_stall_drops_issue();
    idle_inputs(); issue(5'd6, 3'd1); tick();
    idle_inputs(); issue(5'd4, 3'd0); rd_addr = {5'd0, 5'd6}; rd_use = 2'b01;
    #1; n_vec++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL stall_cycle: stall=%0b want 1", stall);
    end
    tick();
    idle_inputs(); rd_addr = {5'd6, 5'd4}; rd_use = 2'b11;
    #1; n_vec++;
    if ({stall, fwd_sel} !== {1'b0, 2'd2, 2'd0}) begin
      n_err++; $display("FAIL stalled_issue_dropped: stall=%0b sel=%h want stall=0 sel=8", stall, fwd_sel);
    end
    drain();
    // A flushed instruction is never recorded.
    idle_inputs(); issue(5'd7, 3'd0); flush = 1'b1; tick();
    idle_inputs(); rd_addr = {5'd0, 5'd7}; rd_use = 2'b01;
    #1; n_vec++;
    if ({stall, fwd_sel} !== '0) begin
      n_err++; $display("FAIL flushed_issue: stall=%0b sel=%h want 0", stall, fwd_sel);
    end
    drain();
  endtask

  task automatic test_depth_edge();
    logic [1:0] want;
    idle_inputs(); issue(5'd10, 3'd0); tick();
    idle_inputs(); rd_addr = {5'd0, 5'd10}; rd_use = 2'b01;
    for (int c = 1; c <= DEPTH + 1; c++) begin
      want = (c <= DEPTH) ? 2'(c) : 2'd0;
      #1; n_vec++;
      if ({stall, fwd_sel} !== {1'b0, 2'd0, want}) begin
        n_err++; $display("FAIL depth_walk age=%0d: stall=%0b sel=%h want sel=%0d", c, stall, fwd_sel, want);
      end
      tick();
    end
    // Latency longer than the tracked window: stalls while visible, then reads the RF.
    idle_inputs(); issue(5'd11, 3'd4); tick();
    idle_inputs(); rd_addr = {5'd0, 5'd11}; rd_use = 2'b01;
    for (int c = 1; c <= DEPTH + 1; c++) begin
      #1; n_vec++;
      if ({stall, fwd_sel} !== {(c <= DEPTH), 2'd0, 2'd0}) begin
        n_err++; $display("FAIL long_lat age=%0d: stall=%0b sel=%h want stall=%0b sel=0", c, stall, fwd_sel, c <= DEPTH);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_midop();
    idle_inputs(); issue(5'd3, 3'd2); tick();
    idle_inputs(); rd_addr = {5'd0, 5'd3}; rd_use = 2'b01;
    #1; n_vec++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_hazard: stall=%0b want 1", stall);
    end
    #1 reset_n = 1'b0;
    model_clear();
    #1; n_vec++;
    if ({md_busy, stall, fwd_sel} !== '0) begin
      n_err++; $display("FAIL async_reset: busy=%0b stall=%0b sel=%h want all 0", md_busy, stall, fwd_sel);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1; n_vec++;
    if ({md_busy, stall, fwd_sel} !== '0) begin
      n_err++; $display("FAIL after_reset_read: busy=%0b stall=%0b sel=%h want all 0", md_busy, stall, fwd_sel);
    end
    drain();
  endtask

  task automatic test_md();
    int busy_cycles;
    idle_inputs(); issue_valid = 1'b1; md_start = 1'b1; tick();
    busy_cycles = 0;
    idle_inputs(); md_use = 1'b1;
    for (int c = 0; c < MUL_LAT + 3; c++) begin
      // A second start while busy must be ignored.
      md_start = (c == 1); issue_valid = (c == 1);
      model_eval();
      #1; n_vec++;
      if ({md_busy, stall} !== {exp_busy, exp_stall}) begin
        n_err++; $display("FAIL md_mult c=%0d: busy=%0b stall=%0b want busy=%0b stall=%0b", c, md_busy, stall, exp_busy, exp_stall);
      end
      busy_cycles += int'(md_busy);
      tick();
    end
    n_vec++;
    if (busy_cycles != (MD_EN ? MUL_LAT : 0)) begin
      n_err++; $display("FAIL md_busy_len: got %0d cycles want %0d", busy_cycles, MD_EN ? MUL_LAT : 0);
    end
    idle_inputs(); issue_valid = 1'b1; md_start = 1'b1; md_is_div = 1'b1; flush = 1'b1; tick();
    idle_inputs(); md_use = 1'b1;
    #1; n_vec++;
    if ({md_busy, stall} !== 2'b00) begin
      n_err++; $display("FAIL md_flush: busy=%0b stall=%0b want 0 0", md_busy, stall);
    end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_wen   = ($urandom_range(0, 4) != 0);
      issue_waddr = 5'($urandom_range(0, 7));
      issue_lat   = 3'($urandom_range(0, 4));
      for (int p = 0; p < NREAD; p++) rd_addr[5*p +: 5] = 5'($urandom_range(0, 7));
      rd_use    = NREAD'($urandom);
      flush     = ($urandom_range(0, 9) == 0);
      md_start  = ($urandom_range(0, 7) == 0);
      md_is_div = 1'($urandom);
      md_use    = ($urandom_range(0, 2) == 0);
      model_eval();
      #1; n_vec++;
      if ({md_busy, stall, fwd_sel} !== {exp_busy, exp_stall, exp_sel_vec()}) begin
        n_err++;
        $display("FAIL random n=%0d: busy=%0b stall=%0b sel=%h want busy=%0b stall=%0b sel=%h",
                 n, md_busy, stall, fwd_sel, exp_busy, exp_stall, exp_sel_vec());
      end
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_youngest();
    test_stall_drops_issue();
    test_depth_edge();
    test_reset_midop();
    test_md();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning number of tracked producer stages after D (slot 1=E, 2=M, 3=W, ...); legal 2..6.
REQ-002 SHALL have parameter NREAD, default 2, meaning number of D-stage register read ports; legal 1..4.
REQ-003 SHALL have parameter MUL_LAT, default 5, meaning multiply busy cycles; legal 1..15.
REQ-004 SHALL have parameter DIV_LAT, default 10, meaning divide busy cycles; legal 1..15.
REQ-005 SHALL define derived SELW = clog2(DEPTH+1).
REQ-006 SHALL have one clock and an asynchronous active-low reset, ports: clk in 1 rising-edge clock; reset_n in 1 async active-low reset.
REQ-007 SHALL have port issue_valid in 1: instruction present in D.
REQ-008 SHALL have port issue_wen in 1: D instruction writes a GPR.
REQ-009 SHALL have port issue_waddr in 5: D destination register.
REQ-010 SHALL have port issue_lat in 3: cycles after entering E until result is forwardable (0 = ALU, 1 = load, ...).
REQ-011 SHALL have port rd_addr in 5*NREAD: packed read addresses, port p at [5p+4:5p].
REQ-012 SHALL have port rd_use in NREAD: per-port "operand actually needed".
REQ-013 SHALL have port flush in 1: kill D-stage instruction (insert bubble).
REQ-014 SHALL have ports md_start in 1 (D starts mult/div), md_is_div in 1, md_use in 1 (D reads HI/LO or starts mult/div).
REQ-015 SHALL have port fwd_sel out SELW*NREAD: per-port source, 0 = register file, k = slot k.
REQ-016 SHALL have ports stall out 1 (hold F/D, bubble into E) and md_busy out 1.

Function
REQ-017 SHALL hold DEPTH slots of {valid, waddr, lat[2:0]}.
REQ-018 Each clock: slot[i+1] <= slot[i] for i=1..DEPTH-1; slot DEPTH discarded; every lat in transit decrements, saturating at 0.
REQ-019 Slot 1 loads {1, issue_waddr, issue_lat} only when issue_valid & issue_wen & issue_waddr!=0 & !stall & !flush; otherwise slot 1 loads invalid.
REQ-020 Per port p with rd_addr!=0: match = smallest k with slot[k].valid & slot[k].waddr==rd_addr.
REQ-021 No match or rd_addr==0 -> fwd_sel[p]=0.
REQ-022 Match with lat==0 -> fwd_sel[p]=k; match with lat!=0 -> fwd_sel[p]=0 and, if rd_use[p], stall=1.
REQ-023 Younger slot always wins over older slots with same address.
REQ-024 fwd_sel and stall SHALL be combinational from registered state and current inputs; zero-cycle latency.
REQ-025 md counter: on md_start & issue_valid & !stall & !flush & count==0 loads DIV_LAT if md_is_div else MUL_LAT; else decrements to 0.
REQ-026 md_busy = (count!=0); md_use & md_busy -> stall=1.
REQ-027 md_start while md_busy SHALL be ignored (already stalled per REQ-026).
REQ-028 flush & stall same cycle -> bubble into slot 1, counter not loaded.

Reset
REQ-029 reset_n low SHALL asynchronously clear all slot valid bits, all lat fields and md counter.
REQ-030 During/after reset: fwd_sel=0, stall=0, md_busy=0; reset mid-operation discards all in-flight entries.

Configuration
REQ-031 Macro FWD_MD_EN defined: md counter, md_busy and md stall per REQ-025..027 present.
REQ-032 FWD_MD_EN undefined: no counter, md_busy tied 0, md_start/md_is_div/md_use ignored, stall from GPR hazards only.

Verification
REQ-033 DEPTH=3,NREAD=2: issue $8 lat0, next cycle rd_addr0=8 -> fwd_sel0=1, stall=0; one cycle later (no new issue) -> fwd_sel0=2.
REQ-034 Issue $9 lat1 (load), next cycle rd_use0=1 rd_addr0=9 -> stall=1 fwd_sel0=0; next cycle -> stall=0 fwd_sel0=2.
REQ-035 Issue $5 then $5 again (different producers), read $5 -> fwd_sel=1 (youngest); read $0 anytime -> fwd_sel=0, stall=0.
REQ-036 FWD_MD_EN, MUL_LAT=5: md_start mult -> md_busy high exactly 5 cycles; md_use during those -> stall=1; after -> stall=0; flush with md_start -> md_busy stays 0.
REQ-037 Issue $3 lat2, assert reset_n=0 next cycle -> all outputs 0 immediately; after release read $3 -> fwd_sel=0, stall=0.
REQ-038 Stall cycle with issue_valid $4 -> $4 not recorded; next cycle read $4 -> fwd_sel=0.
